// File: rtl/instr_cache_2way.sv
// 2-way set-associative instruction cache: multi-word lines, burst refill, pseudo-LRU, flush, hit/miss counters.
// Hit: gnt in the request cycle, rvalid one cycle later. Miss: one memory beat per word; the core request is held until the line arrives.
module instr_cache_2way #(
  parameter int LOG_SETS  = 3,
  parameter int LOG_WORDS = 2,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             res,
  input  logic             flush,
  input  logic             cached_instr_req,
  input  logic [31:0]      cached_instr_adr,
  output logic             cached_instr_gnt,
  output logic             cached_instr_rvalid,
  output logic [31:0]      cached_instr_read,
  output logic             instr_req,
  output logic [31:0]      instr_adr,
  input  logic             instr_gnt,
  input  logic             instr_rvalid,
  input  logic [31:0]      instr_read,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int SETS  = 1 << LOG_SETS;
  localparam int WORDS = 1 << LOG_WORDS;
  localparam int TAG_W = 30 - LOG_SETS - LOG_WORDS;

  typedef enum logic [2:0] {IDLE, RESP, REFILL_REQ, REFILL_WAIT, FLUSH} state_t;

  state_t                 state;
  logic                   flush_pending;
  logic [SETS-1:0]        valid [2];
  logic [SETS-1:0]        lru;
  logic [TAG_W-1:0]       tag_mem  [2][SETS];
  logic [31:0]            data_mem [2][SETS][WORDS];

  logic                   rvalid_q;
  logic [31:0]            read_q;
  logic [TAG_W-1:0]       ref_tag;
  logic [LOG_SETS-1:0]    ref_set;
  logic                   ref_way;
  logic [LOG_WORDS-1:0]   cnt;

  logic [LOG_WORDS-1:0]   a_word;
  logic [LOG_SETS-1:0]    a_set;
  logic [TAG_W-1:0]       a_tag;
  logic                   hit0, hit1, hit, hit_way, victim;
  logic                   take_hit, refill_wr, refill_last;
  logic                   unused_adr_bits;

  assign a_word = cached_instr_adr[LOG_WORDS+1:2];
  assign a_set  = cached_instr_adr[LOG_SETS+LOG_WORDS+1:LOG_WORDS+2];
  assign a_tag  = cached_instr_adr[31:LOG_SETS+LOG_WORDS+2];
  assign unused_adr_bits = ^cached_instr_adr[1:0];

  assign hit0    = valid[0][a_set] && (tag_mem[0][a_set] == a_tag);
  assign hit1    = valid[1][a_set] && (tag_mem[1][a_set] == a_tag);
  assign hit     = hit0 || hit1;
  assign hit_way = hit1;
  // Fill empty ways first so LRU only arbitrates between two live lines.
  assign victim  = !valid[0][a_set] ? 1'b0 : (!valid[1][a_set] ? 1'b1 : lru[a_set]);

  assign take_hit    = !res && (state == IDLE) && !flush && !flush_pending &&
                       cached_instr_req && hit;
  assign refill_wr   = !res && (state == REFILL_WAIT) && instr_rvalid;
  assign refill_last = (cnt == '1);

  assign cached_instr_gnt    = take_hit;
  assign cached_instr_rvalid = rvalid_q;
  assign cached_instr_read   = read_q;
  assign instr_req           = (state == REFILL_REQ);
  assign instr_adr           = {ref_tag, ref_set, cnt, 2'b00};

  always_ff @(posedge clk) begin
    if (refill_wr) begin
      data_mem[ref_way][ref_set][cnt] <= instr_read;
      if (refill_last) tag_mem[ref_way][ref_set] <= ref_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state         <= IDLE;
      flush_pending <= 1'b0;
      valid[0]      <= '0;
      valid[1]      <= '0;
      lru           <= '0;
      rvalid_q      <= 1'b0;
      read_q        <= '0;
      ref_tag       <= '0;
      ref_set       <= '0;
      ref_way       <= 1'b0;
      cnt           <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      rvalid_q <= 1'b0;
      read_q   <= '0;
      // A flush seen outside IDLE is remembered and honoured at the next IDLE.
      if (flush && state != IDLE && state != FLUSH) flush_pending <= 1'b1;
      case (state)
        IDLE: begin
          if (flush || flush_pending) begin
            state <= FLUSH;
          end else if (cached_instr_req) begin
            if (hit) begin
              rvalid_q       <= 1'b1;
              read_q         <= data_mem[hit_way][a_set][a_word];
              lru[a_set]     <= ~hit_way;
              if (hit_count != '1) hit_count <= hit_count + 1'b1;
              state          <= RESP;
            end else begin
              ref_tag        <= a_tag;
              ref_set        <= a_set;
              ref_way        <= victim;
              cnt            <= '0;
              if (miss_count != '1) miss_count <= miss_count + 1'b1;
              state          <= REFILL_REQ;
            end
          end
        end
        RESP: state <= IDLE;
        REFILL_REQ: begin
          if (instr_gnt) state <= REFILL_WAIT;
        end
        REFILL_WAIT: begin
          if (instr_rvalid) begin
            if (cnt == '0) valid[ref_way][ref_set] <= 1'b0;
            if (refill_last) begin
              valid[ref_way][ref_set] <= 1'b1;
              lru[ref_set]            <= ~ref_way;
              state                   <= IDLE;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= REFILL_REQ;
            end
          end
        end
        FLUSH: begin
          valid[0]      <= '0;
          valid[1]      <= '0;
          lru           <= '0;
          flush_pending <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_cache_2way.sv
// Bench for instr_cache_2way: a line-level cache model plus a memory responder and one checker process.
module tb_instr_cache_2way;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             res = 1'b1;
  logic             flush = 1'b0;
  logic             c_req = 1'b0;
  logic [31:0]      c_adr = '0;
  logic             c_gnt, c_rvalid;
  logic [31:0]      c_read;
  logic             m_req;
  logic [31:0]      m_adr;
  logic             m_gnt = 1'b0;
  logic             m_rvalid = 1'b0;
  logic [31:0]      m_read = '0;
  logic [CNT_W-1:0] hit_count, miss_count;

  instr_cache_2way #(.LOG_SETS(3), .LOG_WORDS(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .res(res), .flush(flush),
    .cached_instr_req(c_req), .cached_instr_adr(c_adr),
    .cached_instr_gnt(c_gnt), .cached_instr_rvalid(c_rvalid), .cached_instr_read(c_read),
    .instr_req(m_req), .instr_adr(m_adr), .instr_gnt(m_gnt),
    .instr_rvalid(m_rvalid), .instr_read(m_read),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return 32'h90 + (a >> 2);
  endfunction

  function automatic int sat(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  // Line-level model: which lines are resident, replacement choice, event counts.
  bit          md_valid [2][8];
  int          md_tag   [2][8];
  bit          md_lru   [8];
  int          md_hits, md_misses;
  logic [31:0] exp_mem_q [$];
  logic [31:0] exp_rd_q  [$];

  function automatic void model_clear();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 8; s++) begin
        md_valid[w][s] = 1'b0;
        md_tag[w][s]   = 0;
      end
    for (int s = 0; s < 8; s++) md_lru[s] = 1'b0;
    md_hits   = 0;
    md_misses = 0;
    exp_mem_q.delete();
    exp_rd_q.delete();
  endfunction

  // Returns 1 when the first lookup hits; a miss refills and the held request then hits.
  function automatic bit model_access(input logic [31:0] a, input bit flush_mid);
    int s = int'(a[6:4]);
    int t = int'(a[31:7]);
    bit first = 1'b1;
    bit first_hit = 1'b0;
    bit fm = flush_mid;
    for (int guard = 0; guard < 4; guard++) begin
      int w = -1;
      for (int k = 0; k < 2; k++)
        if (md_valid[k][s] && md_tag[k][s] == t) w = k;
      if (w >= 0) begin
        if (first) first_hit = 1'b1;
        md_lru[s] = (w == 0);
        md_hits++;
        break;
      end
      first = 1'b0;
      md_misses++;
      for (int i = 0; i < 4; i++) exp_mem_q.push_back({a[31:4], 4'b0000} + 32'(i * 4));
      if (fm) begin
        for (int k = 0; k < 2; k++)
          for (int j = 0; j < 8; j++) md_valid[k][j] = 1'b0;
        for (int j = 0; j < 8; j++) md_lru[j] = 1'b0;
        fm = 1'b0;
      end else begin
        int v = !md_valid[0][s] ? 0 : (!md_valid[1][s] ? 1 : int'(md_lru[s]));
        md_valid[v][s] = 1'b1;
        md_tag[v][s]   = t;
        md_lru[s]      = (v == 0);
      end
    end
    exp_rd_q.push_back(mem_val(a));
    return first_hit;
  endfunction

  // Memory responder and the single output checker.
  int          pend = 0;
  logic [31:0] pend_adr = '0;
  bit          stall = 1'b0;
  int          rd_delay = 1;
  bit          flush_arm = 1'b0;
  bit          flush_now = 1'b0;
  bit          flush_next = 1'b0;
  logic [31:0] last_rd = '0;
  logic        prev_req = 1'b0;
  logic        prev_gnt = 1'b0;
  logic [31:0] prev_adr = '0;

  always @(negedge clk) begin
    if (m_req && prev_req && !prev_gnt) check("mem_adr_stable", m_adr, prev_adr);
    if (c_rvalid) begin
      check("rvalid_expected", exp_rd_q.size() != 0, 1);
      if (exp_rd_q.size() != 0) check("read_data", c_read, exp_rd_q.pop_front());
      last_rd = c_read;
    end
    m_rvalid = 1'b0;
    flush    = flush_now || flush_next;
    flush_now  = 1'b0;
    flush_next = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        m_rvalid = 1'b1;
        m_read   = mem_val(pend_adr);
      end
    end
    m_gnt = m_req && !stall && (pend == 0);
    if (m_gnt) begin
      check("mem_req_expected", exp_mem_q.size() != 0, 1);
      if (exp_mem_q.size() != 0) check("mem_adr", m_adr, exp_mem_q.pop_front());
      pend     = rd_delay;
      pend_adr = m_adr;
      if (flush_arm && m_adr[3:2] == 2'd2) begin
        flush_next = 1'b1;
        flush_arm  = 1'b0;
      end
    end
    prev_req = m_req;
    prev_gnt = m_gnt;
    prev_adr = m_adr;
  end

  logic c_hs = 1'b0;
  always @(posedge clk) c_hs <= c_gnt && c_req;

  task automatic do_reset();
    @(negedge clk);
    res   = 1'b1;
    c_req = 1'b0;
    repeat (2) @(negedge clk);
    res = 1'b0;
    model_clear();
    check("rst_instr_req", m_req, 0);
    check("rst_instr_adr", m_adr, 0);
    check("rst_rvalid", c_rvalid, 0);
    check("rst_read", c_read, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_miss_count", miss_count, 0);
  endtask

  task automatic fetch(input logic [31:0] a, input int exp_hit, input bit flush_mid);
    bit first_hit;
    bit done = 1'b0;
    int cyc = 0;
    first_hit = model_access(a, flush_mid);
    if (exp_hit >= 0) check("model_hit_pin", first_hit, exp_hit[0]);
    if (flush_mid) flush_arm = 1'b1;
    @(negedge clk);
    c_req = 1'b1;
    c_adr = a;
    while (!done && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      if (c_hs) done = 1'b1;
    end
    check("granted", done, 1);
    check("hit_same_cycle", cyc == 1, first_hit);
    @(negedge clk);
    c_req = 1'b0;
    @(negedge clk);
    check("rd_queue_drained", exp_rd_q.size(), 0);
    check("mem_queue_drained", exp_mem_q.size(), 0);
    check("hit_count", hit_count, sat(md_hits));
    check("miss_count", miss_count, sat(md_misses));
  endtask

  initial begin
    model_clear();

    // Cold miss then hit in the same line.
    do_reset();
    fetch(32'h40, 0, 1'b0);
    check("cold_read", last_rd, 32'hA0);
    check("cold_miss_count", miss_count, 1);
    check("cold_hit_count", hit_count, 1);
    fetch(32'h48, 1, 1'b0);
    check("hit_read", last_rd, 32'hA2);
    check("hit_hit_count", hit_count, 2);
    fetch(32'h1F4, 0, 1'b0);
    fetch(32'h1F8, 1, 1'b0);

    // Replacement within set 4.
    do_reset();
    fetch(32'h40, 0, 1'b0);
    fetch(32'hC0, 0, 1'b0);
    fetch(32'h40, 1, 1'b0);
    fetch(32'h140, 0, 1'b0);
    check("evict_read", last_rd, 32'hE0);
    fetch(32'h40, 1, 1'b0);
    fetch(32'hC0, 0, 1'b0);

    // Flush during refill: the held request misses again after the flush.
    do_reset();
    fetch(32'h40, 0, 1'b1);
    check("flush_mid_miss_count", miss_count, 2);
    fetch(32'h44, 1, 1'b0);

    // Flush while idle.
    @(negedge clk);
    flush_now = 1'b1;
    model_clear_lines();
    fetch(32'h40, 0, 1'b0);

    // Memory stall, then reset during the outstanding beat.
    do_reset();
    stall    = 1'b1;
    rd_delay = 4;
    void'(model_access(32'h40, 1'b0));
    @(negedge clk);
    c_req = 1'b1;
    c_adr = 32'h40;
    repeat (5) begin
      @(negedge clk);
      check("stall_req", m_req, 1);
      check("stall_adr", m_adr, 32'h40);
    end
    @(posedge clk); #1;
    stall = 1'b0;
    @(posedge clk); #1;
    check("wait_req_low", m_req, 0);
    res   = 1'b1;
    c_req = 1'b0;
    @(posedge clk); #1;
    res = 1'b0;
    model_clear();
    check("midrst_req", m_req, 0);
    check("midrst_hit_count", hit_count, 0);
    check("midrst_miss_count", miss_count, 0);
    repeat (6) @(negedge clk);
    rd_delay = 1;
    fetch(32'h40, 0, 1'b0);
    check("post_rst_miss_count", miss_count, 1);

    // Counter saturation: 17 hits on a 4-bit counter.
    do_reset();
    fetch(32'h40, 0, 1'b0);
    for (int i = 0; i < 16; i++) fetch(32'h40 + 32'((i % 4) * 4), 1, 1'b0);
    check("sat_hit_count", hit_count, 15);
    check("sat_miss_count", miss_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  function automatic void model_clear_lines();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 8; s++) md_valid[w][s] = 1'b0;
    for (int s = 0; s < 8; s++) md_lru[s] = 1'b0;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

endmodule
